// File: rtl/frame_update_sched.sv
// Copies one stable game snapshot (obstacles, then meta) into the VGA shadow
// registers per vertical blank, then pulses commit for the front-buffer swap.
module frame_update_sched #(
  parameter int N_OBS      = 10,
  parameter bit VS_ACT_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vs,
  input  logic        game_clk,
  output logic        copy_en,
  output logic [3:0]  copy_idx,
  output logic        copy_meta,
  output logic        commit,
  output logic        busy,
  output logic [15:0] frame_cnt,
  output logic [7:0]  stale_cnt
);

  typedef enum logic [1:0] {IDLE, COPY, META, COMMIT} state_t;

  localparam logic [3:0] LAST_IDX = 4'(N_OBS - 1);

  state_t     state, state_nxt;
  logic [3:0] idx_nxt;
  logic       pending, pending_nxt;
  logic       frame_inc, stale_inc;
  logic       g1, g2, g3, v1, v2;
  logic       vs_low, g_fall, g_rise, vb_start;

  // vblank begins on the active (low) edge of the pulse regardless of polarity
  assign vs_low   = VS_ACT_LOW ? vs : ~vs;
  assign g_fall   = g3 & ~g2;
  assign g_rise   = ~g3 & g2;
  assign vb_start = v2 & ~v1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      g1 <= 1'b0;
      g2 <= 1'b0;
      g3 <= 1'b0;
      v1 <= 1'b1;
      v2 <= 1'b1;
    end else begin
      g1 <= game_clk;
      g2 <= g1;
      g3 <= g2;
      v1 <= vs_low;
      v2 <= v1;
    end
  end

  always_comb begin
    state_nxt   = state;
    idx_nxt     = copy_idx;
    pending_nxt = pending | g_fall;
    frame_inc   = 1'b0;
    stale_inc   = 1'b0;
    case (state)
      IDLE: begin
        if (vb_start) begin
          if (pending || g_fall) begin
            state_nxt   = COPY;
            idx_nxt     = 4'd0;
            pending_nxt = 1'b0;
          end else begin
            stale_inc = 1'b1;
          end
        end
      end
      COPY: begin
        // game data started changing mid-copy: drop the snapshot
        if (g_rise) begin
          state_nxt = IDLE;
          stale_inc = 1'b1;
        end else if (copy_idx == LAST_IDX) begin
          state_nxt = META;
        end else begin
          idx_nxt = copy_idx + 4'd1;
        end
      end
      META: begin
        if (g_rise) begin
          state_nxt = IDLE;
          stale_inc = 1'b1;
        end else begin
          state_nxt = COMMIT;
        end
      end
      COMMIT: begin
        state_nxt = IDLE;
        frame_inc = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      pending   <= 1'b0;
      copy_en   <= 1'b0;
      copy_idx  <= 4'd0;
      copy_meta <= 1'b0;
      commit    <= 1'b0;
      busy      <= 1'b0;
      frame_cnt <= 16'd0;
      stale_cnt <= 8'd0;
    end else begin
      state     <= state_nxt;
      pending   <= pending_nxt;
      copy_en   <= (state_nxt == COPY);
      copy_idx  <= idx_nxt;
      copy_meta <= (state_nxt == META);
      commit    <= (state_nxt == COMMIT);
      busy      <= (state_nxt != IDLE);
      if (frame_inc)
        frame_cnt <= frame_cnt + 16'd1;
      if (stale_inc && stale_cnt != 8'hFF)
        stale_cnt <= stale_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_frame_update_sched.sv
// Bench for frame_update_sched: directed scenarios plus randomized rounds
// checked against a per-vblank snapshot model.
module tb_frame_update_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        vs = 1'b1;
  logic        game_clk = 1'b0;
  logic        copy_en;
  logic [3:0]  copy_idx;
  logic        copy_meta;
  logic        commit;
  logic        busy;
  logic [15:0] frame_cnt;
  logic [7:0]  stale_cnt;

  frame_update_sched dut (
    .clk(clk), .rst(rst), .vs(vs), .game_clk(game_clk),
    .copy_en(copy_en), .copy_idx(copy_idx), .copy_meta(copy_meta),
    .commit(commit), .busy(busy), .frame_cnt(frame_cnt), .stale_cnt(stale_cnt)
  );

  always #20 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int exp_frame = 0;
  int exp_stale = 0;
  int ev_q[$];
  int ev_cyc[$];
  int mutex_viol = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // event log: obstacle index while copying, 100 for meta, 200 for commit
  always @(negedge clk) begin
    if (copy_en) begin ev_q.push_back(int'(copy_idx)); ev_cyc.push_back(cyc); end
    if (copy_meta) begin ev_q.push_back(100); ev_cyc.push_back(cyc); end
    if (commit) begin ev_q.push_back(200); ev_cyc.push_back(cyc); end
    if ((int'(copy_en) + int'(copy_meta) + int'(commit)) > 1) mutex_viol++;
  end

  function automatic int stale_sat(int s);
    return (s > 255) ? 255 : s;
  endfunction

  function automatic int count_commits();
    int c = 0;
    foreach (ev_q[i]) if (ev_q[i] == 200) c++;
    return c;
  endfunction

  task automatic clear_log();
    ev_q.delete();
    ev_cyc.delete();
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic data_fall();
    @(negedge clk); game_clk = 1'b1;
    wait_cycles(4);
    game_clk = 1'b0;
    wait_cycles(4);
  endtask

  task automatic vblank(output int c0);
    @(negedge clk); vs = 1'b0; c0 = cyc;
    wait_cycles(3);
    vs = 1'b1;
  endtask

  // vblank with game_clk rising d cycles after the vs fall
  task automatic vblank_rise(input int d);
    @(negedge clk); vs = 1'b0;
    if (d == 0) game_clk = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (k == 3) vs = 1'b1;
      if (k == d) game_clk = 1'b1;
    end
  endtask

  task automatic check_counters(input string tag);
    n_checks++;
    if (frame_cnt !== 16'(exp_frame)) begin
      n_fail++;
      $display("FAIL %s frame_cnt: got %0d expected %0d", tag, frame_cnt, 16'(exp_frame));
    end
    n_checks++;
    if (stale_cnt !== 8'(stale_sat(exp_stale))) begin
      n_fail++;
      $display("FAIL %s stale_cnt: got %0d expected %0d", tag, stale_cnt, stale_sat(exp_stale));
    end
  endtask

  task automatic check_full_seq(input string tag, input int c0, input bit check_start);
    int exp_ev;
    n_checks++;
    if (ev_q.size() !== 12) begin
      n_fail++;
      $display("FAIL %s event count: got %0d expected 12", tag, ev_q.size());
    end else begin
      for (int i = 0; i < 12; i++) begin
        exp_ev = (i < 10) ? i : ((i == 10) ? 100 : 200);
        n_checks++;
        if (ev_q[i] !== exp_ev) begin
          n_fail++;
          $display("FAIL %s event %0d: got %0d expected %0d", tag, i, ev_q[i], exp_ev);
        end
      end
      n_checks++;
      if (ev_cyc[11] - ev_cyc[0] !== 11) begin
        n_fail++;
        $display("FAIL %s sequence span: got %0d expected 11", tag, ev_cyc[11] - ev_cyc[0]);
      end
      if (check_start) begin
        n_checks++;
        if (ev_cyc[0] !== c0 + 2) begin
          n_fail++;
          $display("FAIL %s first copy_en cycle: got %0d expected %0d", tag, ev_cyc[0], c0 + 2);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; vs = 1'b1; game_clk = 1'b0;
    wait_cycles(3);
    rst = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      n_checks++;
      if ({copy_en, copy_idx, copy_meta, commit, busy, frame_cnt, stale_cnt} !== 32'd0) begin
        n_fail++;
        $display("FAIL reset_idle cycle %0d: outputs %h expected 0", i,
                 {copy_en, copy_idx, copy_meta, commit, busy, frame_cnt, stale_cnt});
      end
    end
  endtask

  task automatic test_nominal();
    int c0;
    data_fall();
    clear_log();
    vblank(c0);
    wait_cycles(14);
    exp_frame++;
    check_full_seq("nominal", c0, 1'b1);
    check_counters("nominal");
  endtask

  task automatic test_stale();
    int c0;
    for (int r = 0; r < 2; r++) begin
      clear_log();
      vblank(c0);
      wait_cycles(14);
      exp_stale++;
      n_checks++;
      if (ev_q.size() !== 0) begin
        n_fail++;
        $display("FAIL stale events: got %0d expected 0", ev_q.size());
      end
      check_counters("stale");
    end
  endtask

  task automatic test_abort();
    bit ok = 1'b0;
    int c0;
    data_fall();
    clear_log();
    @(negedge clk); vs = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (copy_en && copy_idx == 4'd2) begin ok = 1'b1; break; end
    end
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL abort copy_idx=2 timeout: got none expected idx 2");
    end
    game_clk = 1'b1;
    vs = 1'b1;
    wait_cycles(2);
    n_checks++;
    if ({copy_en, copy_idx} !== {1'b1, 4'd4}) begin
      n_fail++;
      $display("FAIL abort last copy: got en=%0b idx=%0d expected en=1 idx=4", copy_en, copy_idx);
    end
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL abort busy: got %0b expected 0", busy);
    end
    wait_cycles(12);
    exp_stale++;
    n_checks++;
    if (count_commits() !== 0) begin
      n_fail++;
      $display("FAIL abort commits: got %0d expected 0", count_commits());
    end
    check_counters("abort");
    data_fall();
    clear_log();
    vblank(c0);
    wait_cycles(14);
    exp_frame++;
    check_full_seq("abort_recover", c0, 1'b1);
    check_counters("abort_recover");
  endtask

  task automatic test_coincide();
    int c0;
    @(negedge clk); game_clk = 1'b1;
    wait_cycles(4);
    clear_log();
    game_clk = 1'b0;
    vblank(c0);
    wait_cycles(14);
    exp_frame++;
    check_full_seq("bypass", c0, 1'b1);
    check_counters("bypass");
    data_fall();
    clear_log();
    vblank(c0);
    wait_cycles(2);
    vs = 1'b0;
    wait_cycles(3);
    vs = 1'b1;
    wait_cycles(14);
    exp_frame++;
    n_checks++;
    if (count_commits() !== 1) begin
      n_fail++;
      $display("FAIL busy_vblank commits: got %0d expected 1", count_commits());
    end
    check_full_seq("busy_vblank", c0, 1'b1);
    check_counters("busy_vblank");
  endtask

  task automatic test_reset_mid();
    bit ok = 1'b0;
    data_fall();
    @(negedge clk); vs = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (copy_en && copy_idx == 4'd5) begin ok = 1'b1; break; end
    end
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL reset_mid copy_idx=5 timeout: got none expected idx 5");
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if ({copy_en, copy_idx, copy_meta, commit, busy, frame_cnt, stale_cnt} !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_mid outputs: got %h expected 0",
               {copy_en, copy_idx, copy_meta, commit, busy, frame_cnt, stale_cnt});
    end
    vs = 1'b1;
    wait_cycles(2);
    clear_log();
    rst = 1'b0;
    exp_frame = 0;
    exp_stale = 0;
    wait_cycles(16);
    n_checks++;
    if (ev_q.size() !== 0) begin
      n_fail++;
      $display("FAIL reset_mid events after reset: got %0d expected 0", ev_q.size());
    end
    check_counters("reset_mid");
  endtask

  task automatic test_wrap_saturate();
    int c0;
    @(negedge clk);
    force dut.frame_cnt = 16'hFFFF;
    #1;
    release dut.frame_cnt;
    exp_frame = 65535;
    data_fall();
    clear_log();
    vblank(c0);
    wait_cycles(14);
    exp_frame = (exp_frame + 1) % 65536;
    check_full_seq("wrap", c0, 1'b0);
    check_counters("wrap");
    for (int i = 0; i < 300; i++) begin
      vblank(c0);
      wait_cycles(2);
    end
    exp_stale += 300;
    check_counters("saturate");
  endtask

  task automatic test_random();
    int kind, d;
    int c0;
    for (int r = 0; r < 40; r++) begin
      kind = int'($urandom_range(0, 2));
      clear_log();
      if (kind == 0) begin
        data_fall();
        vblank(c0);
        wait_cycles(16);
        exp_frame++;
      end else if (kind == 1) begin
        vblank(c0);
        wait_cycles(16);
        exp_stale++;
      end else begin
        d = int'($urandom_range(0, 14));
        data_fall();
        vblank_rise(d);
        wait_cycles(6);
        // a rise reaching the FSM while it is still copying drops the snapshot
        if (d <= 10) exp_stale++;
        else exp_frame++;
      end
      check_counters($sformatf("random_r%0d_k%0d", r, kind));
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_stale();
    test_abort();
    test_coincide();
    test_random();
    test_reset_mid();
    test_wrap_saturate();
    n_checks++;
    if (mutex_viol !== 0) begin
      n_fail++;
      $display("FAIL exclusivity: got %0d overlapping cycles expected 0", mutex_viol);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
